reservation_station_cdb: RTL
============================

Name: reservation_station_cdb

Overview:
Parametrised successor to the 4-entry reservation station. It holds up to DEPTH renamed instructions waiting for operands, snoops the common data bus (CDB) to wake pending operands, and issues one ready instruction per cycle to its functional unit. Issued entries are freed for reuse. Full state is reported through an in_ready/in_valid handshake. The block sits between rename/dispatch and a single functional unit.

Parameters:
DEPTH, 4, number of entries (power of 2, 2..16)
DATA_W, 16, operand value width
TAG_W, 4, ROB tag width (operand producer tag and instruction ROB index)
INSTR_W, 16, full instruction word width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  dispatch request
in_ready  out  1  an entry is free (combinational from entry-valid bits)
in_rob_idx  in  TAG_W  ROB index of dispatched instruction
in_instr  in  INSTR_W  full instruction word
in_tag1 / in_tag2  in  TAG_W  producer tag of operand 1 / 2
in_val1 / in_val2  in  DATA_W  operand value when already resolved
in_rdy1 / in_rdy2  in  1  operand already resolved (single-operand ops: set rdy2=1)
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  tag of broadcast result
cdb_val  in  DATA_W  broadcast result
fu_busy  in  1  functional unit cannot accept this cycle
flush  in  1  discard all entries (mispredict/exception)
out_valid  out  1  registered: issue valid this cycle
out_rob_idx  out  TAG_W  registered ROB index of issued instruction
out_instr  out  INSTR_W  registered instruction word
out_val1 / out_val2  out  DATA_W  registered resolved operands
occupancy  out  $clog2(DEPTH)+1  registered count of valid entries

Behaviour:
- Reset: all entry valid/rdy bits 0, out_valid 0, out_rob_idx/out_instr/out_val* 0, occupancy 0.
- Accept: the accept handshake is in_valid & in_ready & ~flush. The write goes to the lowest-index free entry. When in_ready=0, in_valid is ignored and the producer must hold the request.
- Dispatch bypass: when cdb_valid is set, an incoming operand with rdy=0 and tag==cdb_tag is stored with rdy=1 and val=cdb_val.
- Wakeup: each cycle, every valid entry with opN not ready and tagN==cdb_tag (cdb_valid=1) sets rdyN=1 and valN=cdb_val. This happens for both operands, in all matching entries simultaneously.
- Select: an entry is ready when valid & rdy1 & rdy2, evaluated on registered state only. The lowest-index ready entry is chosen.
- Issue: when ~fu_busy & ~flush and a ready entry exists, the next edge loads the out_* registers, sets out_valid=1 and clears that entry's valid bit. Otherwise out_valid<=0 and the out_* data registers hold.
- Latency: an instruction accepted with both operands ready at edge N issues at edge N+1 (out_valid high N+1..N+2). An operand woken by the CDB at edge N allows issue at edge N+1.
- Same-cycle free/alloc: the issued entry is not reusable until the next cycle (in_ready uses pre-edge valid bits).
- Full: with DEPTH valid entries, in_ready=0. Issue still proceeds, and in_ready rises the cycle after issue.
- Simultaneous accept + issue: occupancy is unchanged. Accept only: +1. Issue only: -1.
- Flush: the next edge clears all valid bits, sets out_valid<=0 and occupancy<=0. Flush has priority over accept, issue and wakeup.
- Reset mid-operation: asynchronous clear to reset values. Entry payload storage need not be reset.
- CDB tags that match no waiting operand are ignored. Operands already ready are never overwritten.

Decomposition:
- Package rs_pkg holds the default widths (DATA_W, TAG_W, INSTR_W) and a packed entry typedef {valid, rob_idx, instr, tag1, rdy1, val1, tag2, rdy2, val2}.
- Sub-module rs_prio_enc(DEPTH) is a lowest-index one-hot/binary priority encoder. It is instantiated twice: once for free-entry select and once for ready-entry select.

Test Plan:
- Reset, then dispatch rob=3, rdy1=rdy2=1, val1=0x0005, val2=0x0007 -> next cycle out_valid=1, out_rob_idx=3, out_val1=0x0005, out_val2=0x0007; occupancy returns to 0.
- Dispatch rob=1 with tag1=9 not ready; two cycles later cdb_valid, cdb_tag=9, cdb_val=0x1234 -> out_valid one cycle after broadcast with out_val1=0x1234.
- Dispatch with tag2=6 not ready while cdb_tag=6, cdb_val=0xBEEF in the same cycle -> issues next cycle with out_val2=0xBEEF (bypass).
- Fill 4 entries with fu_busy=1 -> in_ready=0, occupancy=4, a 5th request is not accepted; drop fu_busy -> entries 0,1,2,3 issue on consecutive cycles and in_ready=1 after the first issue.
- Two waiting entries (slots 0 and 2) both on tag 5; broadcast tag 5 -> both woken; slot 0 issues first, slot 2 issues the following cycle.
- With 3 entries valid, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, no new entry; a later CDB broadcast causes no issue.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared widths and entry layout for the CDB-snooping reservation station.
package rs_pkg;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned TAG_W   = 4;
   localparam int unsigned INSTR_W = 16;

   // One reservation-station slot at the default widths.
   typedef struct packed {
      logic               valid;
      logic [TAG_W-1:0]   rob_idx;
      logic [INSTR_W-1:0] instr;
      logic [TAG_W-1:0]   tag1;
      logic               rdy1;
      logic [DATA_W-1:0]  val1;
      logic [TAG_W-1:0]   tag2;
      logic               rdy2;
      logic [DATA_W-1:0]  val2;
   } rs_entry_t;

   // Operand wakeup condition: waiting, broadcast present, tags equal.
   function automatic logic cdb_hit(input logic rdy, input logic cdb_valid, input logic eq);
      return ~rdy & cdb_valid & eq;
   endfunction

endpackage

// File: rtl/reservation_station_cdb_if.sv
// Dispatch, CDB, issue and status signals of the reservation station.
interface reservation_station_cdb_if #(
   parameter int unsigned DEPTH   = rs_pkg::DEPTH,
   parameter int unsigned DATA_W  = rs_pkg::DATA_W,
   parameter int unsigned TAG_W   = rs_pkg::TAG_W,
   parameter int unsigned INSTR_W = rs_pkg::INSTR_W
);

   logic                     in_valid;
   logic                     in_ready;
   logic [TAG_W-1:0]         in_rob_idx;
   logic [INSTR_W-1:0]       in_instr;
   logic [TAG_W-1:0]         in_tag1;
   logic [TAG_W-1:0]         in_tag2;
   logic [DATA_W-1:0]        in_val1;
   logic [DATA_W-1:0]        in_val2;
   logic                     in_rdy1;
   logic                     in_rdy2;
   logic                     cdb_valid;
   logic [TAG_W-1:0]         cdb_tag;
   logic [DATA_W-1:0]        cdb_val;
   logic                     fu_busy;
   logic                     flush;
   logic                     out_valid;
   logic [TAG_W-1:0]         out_rob_idx;
   logic [INSTR_W-1:0]       out_instr;
   logic [DATA_W-1:0]        out_val1;
   logic [DATA_W-1:0]        out_val2;
   logic [$clog2(DEPTH):0]   occupancy;

   // Producer side: dispatch, CDB and FU control.
   modport master (
      output in_valid, in_rob_idx, in_instr, in_tag1, in_tag2, in_val1, in_val2,
             in_rdy1, in_rdy2, cdb_valid, cdb_tag, cdb_val, fu_busy, flush,
      input  in_ready, out_valid, out_rob_idx, out_instr, out_val1, out_val2, occupancy
   );

   // Reservation station side.
   modport slave (
      input  in_valid, in_rob_idx, in_instr, in_tag1, in_tag2, in_val1, in_val2,
             in_rdy1, in_rdy2, cdb_valid, cdb_tag, cdb_val, fu_busy, flush,
      output in_ready, out_valid, out_rob_idx, out_instr, out_val1, out_val2, occupancy
   );

endinterface

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder with one-hot and binary outputs.
module rs_prio_enc #(
   parameter int unsigned DEPTH = 4
) (
   input  logic [DEPTH-1:0]         req_i,
   output logic [DEPTH-1:0]         onehot_o,
   output logic [$clog2(DEPTH)-1:0] idx_o,
   output logic                     valid_o
);

   localparam int unsigned IdxW = $clog2(DEPTH);

   // Scan from the top down so the lowest set request wins.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      valid_o  = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
            idx_o       = IdxW'(i);
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station_cdb.sv
// Reservation station: holds renamed ops, wakes operands from the CDB, issues one per cycle.
module reservation_station_cdb
   import rs_pkg::*;
#(
   parameter int unsigned DEPTH   = rs_pkg::DEPTH,
   parameter int unsigned DATA_W  = rs_pkg::DATA_W,
   parameter int unsigned TAG_W   = rs_pkg::TAG_W,
   parameter int unsigned INSTR_W = rs_pkg::INSTR_W
) (
   input logic                      clk,
   input logic                      rst_n,
   reservation_station_cdb_if.slave rs
);

   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned OccW = IdxW + 1;

   // Same layout as rs_pkg::rs_entry_t but at this instance's widths.
   typedef struct packed {
      logic               valid;
      logic [TAG_W-1:0]   rob_idx;
      logic [INSTR_W-1:0] instr;
      logic [TAG_W-1:0]   tag1;
      logic               rdy1;
      logic [DATA_W-1:0]  val1;
      logic [TAG_W-1:0]   tag2;
      logic               rdy2;
      logic [DATA_W-1:0]  val2;
   } entry_t;

   entry_t ent_q [DEPTH];
   entry_t ent_d [DEPTH];
   entry_t new_ent;

   logic [DEPTH-1:0]   free_vec, ready_vec, free_oh, ready_oh;
   logic [IdxW-1:0]    ready_idx;
   logic [IdxW-1:0]    unused_free_idx;  // allocation is driven by the one-hot form
   logic               has_free, has_ready, accept, issue;

   logic               out_valid_q, out_valid_d;
   logic [TAG_W-1:0]   out_rob_q, out_rob_d;
   logic [INSTR_W-1:0] out_instr_q, out_instr_d;
   logic [DATA_W-1:0]  out_val1_q, out_val1_d;
   logic [DATA_W-1:0]  out_val2_q, out_val2_d;
   logic [OccW-1:0]    occ_q, occ_d;

   // Free and ready vectors from registered entry state only.
   always_comb begin
      free_vec  = '0;
      ready_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         free_vec[i]  = ~ent_q[i].valid;
         ready_vec[i] = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
      end
   end

   rs_prio_enc #(
      .DEPTH (DEPTH)
   ) u_free_enc (
      .req_i    (free_vec),
      .onehot_o (free_oh),
      .idx_o    (unused_free_idx),
      .valid_o  (has_free)
   );

   rs_prio_enc #(
      .DEPTH (DEPTH)
   ) u_ready_enc (
      .req_i    (ready_vec),
      .onehot_o (ready_oh),
      .idx_o    (ready_idx),
      .valid_o  (has_ready)
   );

   assign rs.in_ready = has_free;
   assign accept      = rs.in_valid & has_free & ~rs.flush;
   assign issue       = has_ready & ~rs.fu_busy & ~rs.flush;

   // Incoming entry, with operands captured straight off a matching CDB broadcast.
   always_comb begin
      new_ent         = '0;
      new_ent.valid   = 1'b1;
      new_ent.rob_idx = rs.in_rob_idx;
      new_ent.instr   = rs.in_instr;
      new_ent.tag1    = rs.in_tag1;
      new_ent.tag2    = rs.in_tag2;
      new_ent.rdy1    = rs.in_rdy1;
      new_ent.rdy2    = rs.in_rdy2;
      new_ent.val1    = rs.in_val1;
      new_ent.val2    = rs.in_val2;
      if (cdb_hit(rs.in_rdy1, rs.cdb_valid, rs.in_tag1 == rs.cdb_tag)) begin
         new_ent.rdy1 = 1'b1;
         new_ent.val1 = rs.cdb_val;
      end
      if (cdb_hit(rs.in_rdy2, rs.cdb_valid, rs.in_tag2 == rs.cdb_tag)) begin
         new_ent.rdy2 = 1'b1;
         new_ent.val2 = rs.cdb_val;
      end
   end

   // Entry next state: flush beats everything, else wakeup, issue-free, then allocate.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (rs.flush) begin
            ent_d[i].valid = 1'b0;
         end else begin
            if (ent_q[i].valid &&
                cdb_hit(ent_q[i].rdy1, rs.cdb_valid, ent_q[i].tag1 == rs.cdb_tag)) begin
               ent_d[i].rdy1 = 1'b1;
               ent_d[i].val1 = rs.cdb_val;
            end
            if (ent_q[i].valid &&
                cdb_hit(ent_q[i].rdy2, rs.cdb_valid, ent_q[i].tag2 == rs.cdb_tag)) begin
               ent_d[i].rdy2 = 1'b1;
               ent_d[i].val2 = rs.cdb_val;
            end
            if (issue && ready_oh[i]) begin
               ent_d[i].valid = 1'b0;
            end
            // Free slots come from pre-edge valid bits, so never the slot issuing now.
            if (accept && free_oh[i]) begin
               ent_d[i] = new_ent;
            end
         end
      end
   end

   // Issue registers and occupancy counter next state.
   always_comb begin
      out_valid_d = 1'b0;
      out_rob_d   = out_rob_q;
      out_instr_d = out_instr_q;
      out_val1_d  = out_val1_q;
      out_val2_d  = out_val2_q;
      occ_d       = occ_q;
      if (rs.flush) begin
         occ_d = '0;
      end else begin
         if (issue) begin
            out_valid_d = 1'b1;
            out_rob_d   = ent_q[ready_idx].rob_idx;
            out_instr_d = ent_q[ready_idx].instr;
            out_val1_d  = ent_q[ready_idx].val1;
            out_val2_d  = ent_q[ready_idx].val2;
         end
         if (accept && !issue) begin
            occ_d = occ_q + OccW'(1);
         end else if (!accept && issue) begin
            occ_d = occ_q - OccW'(1);
         end
      end
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

   // Registered issue port and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_rob_q   <= '0;
         out_instr_q <= '0;
         out_val1_q  <= '0;
         out_val2_q  <= '0;
         occ_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_rob_q   <= out_rob_d;
         out_instr_q <= out_instr_d;
         out_val1_q  <= out_val1_d;
         out_val2_q  <= out_val2_d;
         occ_q       <= occ_d;
      end
   end

   assign rs.out_valid   = out_valid_q;
   assign rs.out_rob_idx = out_rob_q;
   assign rs.out_instr   = out_instr_q;
   assign rs.out_val1    = out_val1_q;
   assign rs.out_val2    = out_val2_q;
   assign rs.occupancy   = occ_q;

endmodule
